// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Captures retirement events from the core's commit point, classifies
//   them, tags each with an instruction number and queues the records in a
//   FIFO drained over a valid/ready port. Never back-pressures the core:
//   when the FIFO is full and nothing pops, the record is dropped and
//   counted. A halt-drain FSM (RUN -> DRAIN -> DONE) stops accepting
//   commits after HALT and raises done once the FIFO is empty.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     commit_*              retirement event from the core
//     out_valid/out_ready   record handshake; out_* are the record fields
//     out_kind              0 NOP, 1 REG, 2 LD, 3 STU, 4 ST, 5 HALT
//     out_cycle             cycle stamp of the record (0 when not built in)
//     level                 FIFO occupancy
//     overflow, drop_cnt    sticky drop flag, saturating drop counter
//     inst_count            commits accepted in RUN
//     cycle_cnt             cycles since reset, frozen in DONE
//     done                  halt seen and FIFO drained
//
//   Build option: define CYCLE_STAMP_EN to store cycle_cnt with every
//   record and present it on out_cycle.
module commit_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       commit_valid,
  input  logic [DATA_W-1:0]          commit_pc,
  input  logic [DATA_W-1:0]          commit_inst,
  input  logic                       commit_reg_write,
  input  logic [REG_W-1:0]           commit_write_reg,
  input  logic [DATA_W-1:0]          commit_write_data,
  input  logic                       commit_mem_read,
  input  logic                       commit_mem_write,
  input  logic [DATA_W-1:0]          commit_mem_addr,
  input  logic [DATA_W-1:0]          commit_mem_data,
  input  logic                       commit_halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_kind,
  output logic [CNT_W-1:0]           out_inum,
  output logic [DATA_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_inst,
  output logic [REG_W-1:0]           out_reg,
  output logic [DATA_W-1:0]          out_wdata,
  output logic [DATA_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_mdata,
  output logic [CNT_W-1:0]           out_cycle,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [CNT_W-1:0]           inst_count,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    KIND_NOP  = 3'd0,
    KIND_REG  = 3'd1,
    KIND_LD   = 3'd2,
    KIND_STU  = 3'd3,
    KIND_ST   = 3'd4,
    KIND_HALT = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [2:0]        kind;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
  } rec_t;

  state_e           state, nextState;
  rec_t             mem [DEPTH];
  rec_t             newRec;
  rec_t             headRec;
  kind_e            kind;
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [LW-1:0]    levelQ;
  logic [CNT_W-1:0] instQ, cycleQ, dropQ;
  logic             overflowQ;
  logic             accept, full, pop, push, drop, notEmpty;

  // Classification: register-writing forms take priority over HALT/ST.
  always_comb begin
    kind = KIND_NOP;
    if (commit_reg_write && commit_mem_write)     kind = KIND_STU;
    else if (commit_reg_write && commit_mem_read) kind = KIND_LD;
    else if (commit_reg_write)                    kind = KIND_REG;
    else if (commit_halt)                         kind = KIND_HALT;
    else if (commit_mem_write)                    kind = KIND_ST;
  end

  always_comb begin
    newRec.kind  = kind;
    newRec.inum  = instQ;
    newRec.pc    = commit_pc;
    newRec.inst  = commit_inst;
    newRec.rg    = commit_write_reg;
    newRec.wdata = commit_write_data;
    newRec.addr  = commit_mem_addr;
    newRec.mdata = commit_mem_data;
  end

  assign notEmpty = (levelQ != '0);
  assign full     = (levelQ == LW'(DEPTH));
  assign accept   = commit_valid && (state == ST_RUN);
  assign pop      = notEmpty && out_ready;
  // A pop on the same edge frees a slot, so a full FIFO still takes the push.
  assign push     = accept && (!full || pop);
  assign drop     = accept && full && !pop;

  // Storage is not reset; the read side is gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= newRec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      levelQ    <= '0;
      overflowQ <= 1'b0;
      dropQ     <= '0;
      instQ     <= '0;
      cycleQ    <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      if (push && !pop)      levelQ <= levelQ + LW'(1);
      else if (pop && !push) levelQ <= levelQ - LW'(1);
      if (drop) begin
        overflowQ <= 1'b1;
        if (dropQ != '1) dropQ <= dropQ + CNT_W'(1);
      end
      // Dropped records still consume an INUM so gaps are visible downstream.
      if (accept) instQ <= instQ + CNT_W'(1);
      if (state != ST_DONE) cycleQ <= cycleQ + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    done      = 1'b0;
    case (state)
      ST_RUN:   if (accept && commit_halt) nextState = ST_DRAIN;
      ST_DRAIN: if (!notEmpty) nextState = ST_DONE;
      ST_DONE:  done = 1'b1;
      default:  nextState = ST_RUN;
    endcase
  end

  always_comb begin
    headRec = notEmpty ? mem[rdPtr] : '0;
    out_valid = notEmpty;
    out_kind  = headRec.kind;
    out_inum  = headRec.inum;
    out_pc    = headRec.pc;
    out_inst  = headRec.inst;
    out_reg   = headRec.rg;
    out_wdata = headRec.wdata;
    out_addr  = headRec.addr;
    out_mdata = headRec.mdata;
  end

`ifdef CYCLE_STAMP_EN
  logic [CNT_W-1:0] stampMem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) stampMem[wrPtr] <= cycleQ;
  end

  assign out_cycle = notEmpty ? stampMem[rdPtr] : '0;
`else
  assign out_cycle = '0;
`endif

  assign level      = levelQ;
  assign overflow   = overflowQ;
  assign drop_cnt   = dropQ;
  assign inst_count = instQ;
  assign cycle_cnt  = cycleQ;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable successor to the simulation-only commit tracer: captures per-instruction retirement events from the WB/commit point of the pipelined core.
- Classifies each event (REG/LD/STU/ST/NOP/HALT) and tags it with an instruction number.
- Buffers records in a parametrised FIFO drained over a valid/ready port (trace dump, debug UART, or on-chip checker).
- Owns instruction/cycle counters and a halt-drain state machine; never stalls the core.

Parameters:
DATA_W, 16, width of PC, instruction, register data, memory address/data
REG_W, 3, register specifier width
DEPTH, 16, FIFO entries; power of two, >= 2
CNT_W, 32, width of INUM, cycle, instruction and drop counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
commit_valid  in  1  one instruction retires this cycle
commit_pc  in  DATA_W  PC of retiring instruction
commit_inst  in  DATA_W  instruction word
commit_reg_write  in  1  register file written
commit_write_reg  in  REG_W  destination register
commit_write_data  in  DATA_W  register write data
commit_mem_read  in  1  load
commit_mem_write  in  1  store
commit_mem_addr  in  DATA_W  memory address
commit_mem_data  in  DATA_W  store data
commit_halt  in  1  HALT retiring
out_valid  out  1  record available
out_ready  in  1  consumer accepts record
out_kind  out  3  0 NOP/branch, 1 REG, 2 LD, 3 STU, 4 ST, 5 HALT
out_inum  out  CNT_W  instruction number
out_pc, out_inst, out_reg, out_wdata, out_addr, out_mdata  out  DATA_W/REG_W  captured fields
out_cycle  out  CNT_W  cycle stamp (see Optional Feature)
level  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a record was dropped
drop_cnt  out  CNT_W  records dropped, saturating
inst_count  out  CNT_W  commits accepted by FSM
cycle_cnt  out  CNT_W  cycles since reset, frozen in DONE
done  out  1  halt seen and FIFO drained

Behaviour:
- Reset (async, rst_n low): FIFO empty, out_valid=0, all out_* fields 0, level=0, overflow=0, all counters 0, done=0, FSM=RUN. Reset mid-operation discards all queued records immediately.
- Classification, in priority order:
  - reg_write & mem_write -> STU
  - reg_write & mem_read -> LD
  - reg_write -> REG
  - halt -> HALT
  - mem_write -> ST
  - else NOP
- Unused fields of a record are stored as presented; no masking.
- INUM: equals inst_count before increment. Every commit_valid in RUN consumes one INUM, including dropped records, so gaps are visible downstream.
- Latency: commit accepted at edge N -> out_valid=1 after edge N (visible cycle N+1) if FIFO was empty. No combinational input->output path.
- Handshake: pop on out_valid & out_ready at clk edge. Record fields hold stable while out_valid & !out_ready.
- Full handling:
  - If level==DEPTH and a pop occurs the same edge, the push is accepted; level is unchanged.
  - If level==DEPTH with no pop, the record is dropped, overflow is set, and drop_cnt increments (saturates at all-ones).
  - Empty FIFO with out_ready held high: no spurious pop; level never underflows.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
- FSM:
  - RUN: accept commits. A HALT commit (queued or dropped) -> DRAIN.
  - DRAIN: commit_valid ignored (no push, no count); when level==0 -> DONE.
  - DONE: done=1, cycle_cnt frozen, commits ignored; exit only via reset.
- cycle_cnt: increments every cycle in RUN and DRAIN; wraps at 2^CNT_W.

Optional Feature:
- CYCLE_STAMP_EN defined: each FIFO entry additionally stores the cycle_cnt value at push; out_cycle presents it with the record.
- Undefined: no storage is added and out_cycle is tied to 0.

Test Plan:
- Reset mid-stream: 3 records queued, rst_n pulsed low between edges -> out_valid=0, level=0, inst_count=0 asynchronously; next commit gets INUM 0.
- Mixed stream with out_ready=1:
  - REG r3=0x0005 @PC 0x0000 -> kind 1, INUM 0
  - LD r1 from 0x0010 -> kind 2, INUM 1
  - STU -> kind 3, INUM 2
  - ST 0xBEEF to 0x0020 -> kind 4, INUM 3
  - NOP -> kind 0, INUM 4
  - Each record appears exactly one cycle after its commit.
- DEPTH=4, out_ready=0, 6 commits -> level=4, drop_cnt=2, overflow=1. Drain 4 records with INUM 0..3. Next commit gets INUM 6.
- Full FIFO, commit while out_valid & out_ready -> push accepted, level stays 4, drop_cnt unchanged.
- HALT @PC 0x0040 with 2 records queued -> DRAIN, a later commit is ignored (inst_count stays 3), done=1 one cycle after level reaches 0, cycle_cnt frozen.
- With CYCLE_STAMP_EN, commits at cycles 5 and 9 -> out_cycle 5 then 9. Without the macro -> out_cycle=0.
